// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: load-use, instruction/data memory wait and taken-branch
// handling with zero-latency stall/flush controls, a stall performance counter and an imem timeout flag.
module pipeline_hazard_controller #(
  parameter int unsigned STALL_CNT_W  = 16,
  parameter int unsigned IMEM_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_usesRs,
  input  logic                   id_usesRt,
  input  logic                   ex_memRead,
  input  logic [4:0]             ex_rd,
  input  logic                   id_branchTaken,
  input  logic                   imem_ready,
  input  logic                   dmem_busy,
  output logic                   pc_shouldStall,
  output logic                   id_shouldStall,
  output logic                   if_shouldFlush,
  output logic                   ex_shouldStall,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   timeout_err
);

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    IMEM_WAIT  = 2'd2,
    DMEM_WAIT  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic                   err_q, err_d;
  logic                   hz_c;

  // Load-use hazard: EX load writes a register the ID instruction reads (r0 never hazards)
  assign hz_c = ex_memRead & (ex_rd != 5'd0) &
                ((id_usesRs & (id_rs == ex_rd)) | (id_usesRt & (id_rt == ex_rd)));

  // Mealy control outputs and next state, fixed priority dmem > imem > load-use > branch
  always_comb begin
    pc_shouldStall = 1'b0;
    id_shouldStall = 1'b0;
    if_shouldFlush = 1'b0;
    ex_shouldStall = 1'b0;
    state_d        = RUN;
    if (rst) begin
      state_d = RUN;
    end else if (dmem_busy) begin
      pc_shouldStall = 1'b1;
      id_shouldStall = 1'b1;
      ex_shouldStall = 1'b1;
      state_d        = DMEM_WAIT;
    end else if (!imem_ready) begin
      pc_shouldStall = 1'b1;
      id_shouldStall = 1'b1;
      state_d        = IMEM_WAIT;
    end else if (hz_c && (state_q != LOAD_STALL)) begin
      pc_shouldStall = 1'b1;
      id_shouldStall = 1'b1;
      state_d        = LOAD_STALL;
    end else if (id_branchTaken) begin
      if_shouldFlush = 1'b1;
      state_d        = RUN;
    end
  end

  // Saturating stall counter, imem wait counter and sticky timeout
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_shouldStall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
    wait_d = wait_q;
    if (imem_ready || dmem_busy) begin
      wait_d = '0;
    end else if (wait_q != {WAIT_W{1'b1}}) begin
      wait_d = wait_q + WAIT_W'(1);
    end
    err_d = err_q | (wait_d >= WAIT_W'(IMEM_TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      wait_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
    end
  end

  assign state       = state_q;
  assign stall_count = stall_cnt_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed vector table, corner sequences and
// random stimulus against a behavioural model of the hazard rules.
module tb_pipeline_hazard_controller;

  localparam int unsigned SCW = 6;
  localparam int unsigned TMO = 4;
  localparam int SC_MAX = (1 << SCW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic       urs, urt, mr;
    logic [4:0] rd;
    logic       br, ir, db;
  } in_t;

  typedef struct {
    in_t i;
    bit  pc, id, fl, ex;
    int  st;
    int  sc;
  } vec_t;

  logic           rst, id_usesRs, id_usesRt, ex_memRead, id_branchTaken, imem_ready, dmem_busy;
  logic [4:0]     id_rs, id_rt, ex_rd;
  logic           pc_shouldStall, id_shouldStall, if_shouldFlush, ex_shouldStall, timeout_err;
  logic [1:0]     state;
  logic [SCW-1:0] stall_count;

  pipeline_hazard_controller #(.STALL_CNT_W(SCW), .IMEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_usesRs(id_usesRs),
    .id_usesRt(id_usesRt), .ex_memRead(ex_memRead), .ex_rd(ex_rd),
    .id_branchTaken(id_branchTaken), .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .pc_shouldStall(pc_shouldStall), .id_shouldStall(id_shouldStall),
    .if_shouldFlush(if_shouldFlush), .ex_shouldStall(ex_shouldStall), .state(state),
    .stall_count(stall_count), .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: mode 0 run, 1 load stall, 2 imem wait, 3 dmem wait
  int m_mode = 0, m_sc = 0, m_wait = 0;
  bit m_err = 0;
  bit e_pc, e_id, e_fl, e_ex;
  int e_next;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(bit r, int rs, int rt, bit urs, bit urt, bit mr, int rd,
                             bit br, bit ir, bit db);
    in_t x;
    x.rst = r; x.rs = 5'(rs); x.rt = 5'(rt); x.urs = urs; x.urt = urt; x.mr = mr;
    x.rd = 5'(rd); x.br = br; x.ir = ir; x.db = db;
    return x;
  endfunction

  function automatic vec_t mv(in_t x, bit pc, bit id, bit fl, bit ex, int st, int sc);
    vec_t v;
    v.i = x; v.pc = pc; v.id = id; v.fl = fl; v.ex = ex; v.st = st; v.sc = sc;
    return v;
  endfunction

  task automatic drive(input in_t x);
    rst = x.rst; id_rs = x.rs; id_rt = x.rt; id_usesRs = x.urs; id_usesRt = x.urt;
    ex_memRead = x.mr; ex_rd = x.rd; id_branchTaken = x.br; imem_ready = x.ir;
    dmem_busy = x.db;
  endtask

  // Expected controls for this cycle from the hazard rules
  task automatic model_eval(input in_t x);
    bit hz;
    hz = x.mr && (x.rd != 0) && ((x.urs && x.rs == x.rd) || (x.urt && x.rt == x.rd));
    {e_pc, e_id, e_fl, e_ex} = 4'b0000;
    e_next = 0;
    if (x.rst) e_next = 0;
    else if (x.db) begin e_pc = 1; e_id = 1; e_ex = 1; e_next = 3; end
    else if (!x.ir) begin e_pc = 1; e_id = 1; e_next = 2; end
    else if (hz && m_mode != 1) begin e_pc = 1; e_id = 1; e_next = 1; end
    else if (x.br) e_fl = 1;
  endtask

  task automatic model_clock(input in_t x);
    if (x.rst) begin
      m_mode = 0; m_sc = 0; m_wait = 0; m_err = 0;
    end else begin
      m_mode = e_next;
      if (e_pc && m_sc < SC_MAX) m_sc++;
      if (x.ir || x.db) m_wait = 0;
      else if (m_wait < 255) m_wait++;
      if (m_wait >= TMO) m_err = 1;
    end
  endtask

  // One cycle: drive, compare mid-cycle against the model, then advance on the edge
  task automatic step(input in_t x);
    drive(x);
    model_eval(x);
    @(negedge clk);
    chk("pc_stall", int'(pc_shouldStall), int'(e_pc));
    chk("id_stall", int'(id_shouldStall), int'(e_id));
    chk("if_flush", int'(if_shouldFlush), int'(e_fl));
    chk("ex_stall", int'(ex_shouldStall), int'(e_ex));
    chk("state", int'(state), m_mode);
    chk("stall_count", int'(stall_count), m_sc);
    chk("timeout_err", int'(timeout_err), int'(m_err));
    @(posedge clk);
    model_clock(x);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    in_t IDLE, HZ, Z0, RT, BR, BRW, DB, NOUSE, DBI, RSTDB, IMW, RST, x;

    IDLE  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    HZ    = mk(0, 5, 0, 1, 0, 1, 5, 0, 1, 0);
    Z0    = mk(0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    RT    = mk(0, 0, 7, 0, 1, 1, 7, 0, 1, 0);
    BR    = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    BRW   = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    DB    = mk(0, 5, 0, 1, 0, 1, 5, 0, 0, 1);
    NOUSE = mk(0, 5, 0, 0, 0, 1, 5, 0, 1, 0);
    DBI   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    RSTDB = mk(1, 5, 0, 1, 0, 1, 5, 1, 0, 1);
    IMW   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    RST   = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    //                 pc id fl ex st sc
    tbl.push_back(mv(HZ,    1, 1, 0, 0, 0, 0));
    tbl.push_back(mv(HZ,    0, 0, 0, 0, 1, 1));
    tbl.push_back(mv(IDLE,  0, 0, 0, 0, 0, 1));
    tbl.push_back(mv(Z0,    0, 0, 0, 0, 0, 1));
    tbl.push_back(mv(RT,    1, 1, 0, 0, 0, 1));
    tbl.push_back(mv(IDLE,  0, 0, 0, 0, 1, 2));
    tbl.push_back(mv(BR,    0, 0, 1, 0, 0, 2));
    tbl.push_back(mv(BRW,   1, 1, 0, 0, 0, 2));
    tbl.push_back(mv(BRW,   1, 1, 0, 0, 2, 3));
    tbl.push_back(mv(BRW,   1, 1, 0, 0, 2, 4));
    tbl.push_back(mv(BR,    0, 0, 1, 0, 2, 5));
    tbl.push_back(mv(IDLE,  0, 0, 0, 0, 0, 5));
    tbl.push_back(mv(DB,    1, 1, 0, 1, 0, 5));
    tbl.push_back(mv(DB,    1, 1, 0, 1, 3, 6));
    tbl.push_back(mv(DB,    1, 1, 0, 1, 3, 7));
    tbl.push_back(mv(DB,    1, 1, 0, 1, 3, 8));
    tbl.push_back(mv(HZ,    1, 1, 0, 0, 3, 9));
    tbl.push_back(mv(HZ,    0, 0, 0, 0, 1, 10));
    tbl.push_back(mv(IDLE,  0, 0, 0, 0, 0, 10));
    tbl.push_back(mv(NOUSE, 0, 0, 0, 0, 0, 10));
    tbl.push_back(mv(DBI,   1, 1, 0, 1, 0, 10));
    tbl.push_back(mv(DBI,   1, 1, 0, 1, 3, 11));
    tbl.push_back(mv(RSTDB, 0, 0, 0, 0, 3, 12));
    tbl.push_back(mv(IDLE,  0, 0, 0, 0, 0, 0));

    drive(RST);
    @(posedge clk);
    #1;
    step(RST);

    // Directed table against hand-derived expectations
    foreach (tbl[k]) begin
      drive(tbl[k].i);
      @(negedge clk);
      chk($sformatf("vec%0d_pc", k), int'(pc_shouldStall), int'(tbl[k].pc));
      chk($sformatf("vec%0d_id", k), int'(id_shouldStall), int'(tbl[k].id));
      chk($sformatf("vec%0d_fl", k), int'(if_shouldFlush), int'(tbl[k].fl));
      chk($sformatf("vec%0d_ex", k), int'(ex_shouldStall), int'(tbl[k].ex));
      chk($sformatf("vec%0d_st", k), int'(state), tbl[k].st);
      chk($sformatf("vec%0d_sc", k), int'(stall_count), tbl[k].sc);
      chk($sformatf("vec%0d_to", k), int'(timeout_err), 0);
      @(posedge clk);
      model_eval(tbl[k].i);
      model_clock(tbl[k].i);
      #1;
    end

    // Imem timeout rises after the 4th wait cycle and stays until reset
    for (int k = 1; k <= 6; k++) begin
      step(IMW);
      chk($sformatf("tmo_wait%0d", k), int'(timeout_err), (k >= 4) ? 1 : 0);
    end
    step(IDLE);
    chk("tmo_sticky", int'(timeout_err), 1);
    step(IDLE);
    chk("tmo_sticky2", int'(timeout_err), 1);
    step(RST);
    chk("tmo_reset", int'(timeout_err), 0);

    // Stall counter saturates at all ones
    for (int k = 0; k < 70; k++) step(DBI);
    chk("sc_saturate", int'(stall_count), SC_MAX);
    step(RST);
    chk("sc_reset", int'(stall_count), 0);

    // Random stimulus against the model; small register range makes hazards common
    for (int k = 0; k < 3000; k++) begin
      x.rst = ($urandom_range(0, 59) == 0);
      x.rs  = 5'($urandom_range(0, 3));
      x.rt  = 5'($urandom_range(0, 3));
      x.urs = 1'($urandom_range(0, 1));
      x.urt = 1'($urandom_range(0, 1));
      x.mr  = ($urandom_range(0, 2) != 0);
      x.rd  = 5'($urandom_range(0, 3));
      x.br  = ($urandom_range(0, 3) == 0);
      x.ir  = ($urandom_range(0, 4) != 0);
      x.db  = ($urandom_range(0, 5) == 0);
      step(x);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
